// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: captures a fetched instruction, classifies it, and steps through
// operand read, ALU strobe and writeback. Optional RMW dummy write via RMW_DUMMY_WRITE_EN.
module exec_sequencer #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  instruction_ready,
    input  logic [REG_WIDTH-1:0]  instruction_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [REG_WIDTH-1:0]  imm_in,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic [REG_WIDTH-1:0]  store_data,
    input  logic [REG_WIDTH-1:0]  alu_result,
    output logic                  instruction_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic [REG_WIDTH-1:0]  alu_a,
    output logic [REG_WIDTH-1:0]  alu_op,
    output logic                  alu_go,
    output logic                  reg_we,
    output logic [1:0]            store_sel,
    output logic                  seq_err
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_READ,
        S_EXEC,
`ifdef RMW_DUMMY_WRITE_EN
        S_DUMMY,
`endif
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        C_IMPLIED,
        C_IMM,
        C_LOAD,
        C_STORE,
        C_RMW
    } class_t;

    // Decode on the 6502 aaa/bbb/cc opcode fields; cc=11 has no defined class and runs as IMPLIED.
    function automatic class_t classify(input logic [7:0] op);
        logic [2:0] aaa;
        logic [2:0] bbb;
        class_t     c;
        aaa = op[7:5];
        bbb = op[4:2];
        c   = C_IMPLIED;
        unique case (op[1:0])
            2'b01: begin
                if (aaa == 3'b100)      c = C_STORE;
                else if (bbb == 3'b010) c = C_IMM;
                else                    c = C_LOAD;
            end
            2'b10: begin
                if (aaa == 3'b100)      c = C_STORE;
                else if (aaa == 3'b101) c = (bbb == 3'b000) ? C_IMM : C_LOAD;
                else if (bbb == 3'b010) c = C_IMPLIED;
                else                    c = C_RMW;
            end
            2'b00: begin
                if (aaa == 3'b100)      c = C_STORE;
                else if (aaa == 3'b101) c = (bbb == 3'b000) ? C_IMM : C_LOAD;
                else                    c = C_IMPLIED;
            end
            default: c = C_IMPLIED;
        endcase
        return c;
    endfunction

    state_t                state_q,   state_d;
    class_t                class_q,   class_d;
    logic                  ready_q;
    logic                  seq_err_q, seq_err_d;
    logic [REG_WIDTH-1:0]  opcode_q,  opcode_d;
    logic [REG_WIDTH-1:0]  imm_q,     imm_d;
    logic [REG_WIDTH-1:0]  operand_q, operand_d;
    logic [REG_WIDTH-1:0]  result_q,  result_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic                  rise;

    assign rise = instruction_ready & ~ready_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        class_d          = class_q;
        seq_err_d        = seq_err_q;
        opcode_d         = opcode_q;
        imm_d            = imm_q;
        operand_d        = operand_q;
        result_d         = result_q;
        addr_d           = addr_q;
        instruction_done = 1'b0;
        mem_addr         = '0;
        mem_we           = 1'b0;
        mem_wdata        = '0;
        alu_a            = '0;
        alu_go           = 1'b0;
        reg_we           = 1'b0;

        unique case (state_q)
            S_BOOT: state_d = S_DONE;
            S_IDLE: begin
                if (rise) begin
                    opcode_d = instruction_in;
                    addr_d   = addr_in;
                    imm_d    = imm_in;
                    class_d  = classify(instruction_in[7:0]);
                    unique case (class_d)
                        C_LOAD, C_RMW: state_d = S_READ;
                        C_STORE:       state_d = S_WRITE;
                        default:       state_d = S_EXEC;
                    endcase
                end
            end
            S_READ: begin
                mem_addr  = addr_q;
                operand_d = mem_rdata;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                alu_go = 1'b1;
                reg_we = (class_q != C_RMW);
                unique case (class_q)
                    C_LOAD, C_RMW: alu_a = operand_q;
                    C_IMM:         alu_a = imm_q;
                    default:       alu_a = '0;
                endcase
                if (class_q == C_RMW) begin
                    result_d = alu_result;
`ifdef RMW_DUMMY_WRITE_EN
                    state_d  = S_DUMMY;
`else
                    state_d  = S_WRITE;
`endif
                end else begin
                    state_d = S_DONE;
                end
            end
`ifdef RMW_DUMMY_WRITE_EN
            // NMOS bus behaviour: the unmodified operand is written back before the result.
            S_DUMMY: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = operand_q;
                state_d   = S_WRITE;
            end
`endif
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = (class_q == C_STORE) ? store_data : result_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                instruction_done = 1'b1;
                state_d          = S_IDLE;
            end
            default: state_d = S_BOOT;
        endcase

        // A new instruction edge can only be accepted in IDLE; DONE drops it silently.
        if (rise && (state_q != S_IDLE) && (state_q != S_DONE)) seq_err_d = 1'b1;
    end

    assign alu_op  = opcode_q;
    assign seq_err = seq_err_q;
    always_comb begin
        unique case (opcode_q[1:0])
            2'b10:   store_sel = 2'b01;
            2'b00:   store_sel = 2'b10;
            default: store_sel = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            state_q   <= S_BOOT;
            class_q   <= C_IMPLIED;
            ready_q   <= 1'b1;
            seq_err_q <= 1'b0;
            opcode_q  <= '0;
            imm_q     <= '0;
            operand_q <= '0;
            result_q  <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            ready_q   <= instruction_ready;
            seq_err_q <= seq_err_d;
            opcode_q  <= opcode_d;
            imm_q     <= imm_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            addr_q    <= addr_d;
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: stimulus pushes expected ALU/write/done events,
// a negedge monitor pops and compares them as the DUT presents strobes.
module tb_exec_sequencer;

    typedef enum int {EV_ALU, EV_WR, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       f1;
        int       f2;
        int       f3;
        string    tag;
    } ev_t;

    logic        phi1 = 1'b0;
    logic        reset = 1'b1;
    logic        instruction_ready = 1'b1;
    logic [7:0]  instruction_in = '0;
    logic [15:0] addr_in = '0;
    logic [7:0]  imm_in = '0;
    logic [7:0]  mem_rdata, store_data, alu_result;
    logic        instruction_done, mem_we, alu_go, reg_we, seq_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, alu_a, alu_op;
    logic [1:0]  store_sel;

    int  cyc = 0;
    int  pass_cnt = 0;
    int  total_cnt = 0;
    ev_t exp_q[$];

    exec_sequencer #(.REG_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .phi1(phi1), .reset(reset), .instruction_ready(instruction_ready),
        .instruction_in(instruction_in), .addr_in(addr_in), .imm_in(imm_in),
        .mem_rdata(mem_rdata), .store_data(store_data), .alu_result(alu_result),
        .instruction_done(instruction_done), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .alu_a(alu_a), .alu_op(alu_op), .alu_go(alu_go),
        .reg_we(reg_we), .store_sel(store_sel), .seq_err(seq_err)
    );

    always #5 phi1 = ~phi1;
    always @(posedge phi1) cyc <= cyc + 1;

    // Memory, register file and ALU stand-ins.
    always_comb begin
        mem_rdata = 8'h00;
        if (mem_addr == 16'h0310) mem_rdata = 8'h5A;
        if (mem_addr == 16'h0040) mem_rdata = 8'hFE;
        case (store_sel)
            2'b00:   store_data = 8'h11;
            2'b01:   store_data = 8'h77;
            2'b10:   store_data = 8'h33;
            default: store_data = 8'h00;
        endcase
        alu_result = alu_a + 8'h01;
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void push(input ev_kind_t k, input int c, input int f1, input int f2,
                                 input int f3, input string tag);
        ev_t e;
        e.kind = k; e.cyc = c; e.f1 = f1; e.f2 = f2; e.f3 = f3; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    task automatic got(input ev_kind_t k, input int f1, input int f2, input int f3);
        ev_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".kind"}, k, e.kind);
            check({e.tag, ".cyc"}, cyc, e.cyc);
            if (k == e.kind) begin
                check({e.tag, ".f1"}, f1, e.f1);
                check({e.tag, ".f2"}, f2, e.f2);
                check({e.tag, ".f3"}, f3, e.f3);
            end
        end
    endtask

    always @(negedge phi1) begin
        if (alu_go)           got(EV_ALU, int'(alu_a), int'(alu_op), int'(reg_we));
        if (mem_we)           got(EV_WR, int'(mem_addr), int'(mem_wdata), 0);
        if (instruction_done) got(EV_DONE, 0, 0, 0);
    end

    task automatic issue(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] imm,
                         output int k);
        @(negedge phi1);
        instruction_in    = op;
        addr_in           = addr;
        imm_in            = imm;
        instruction_ready = 1'b1;
        k = cyc;
    endtask

    task automatic retire(input int n);
        repeat (n) @(negedge phi1);
        instruction_ready = 1'b0;
        repeat (2) @(negedge phi1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge phi1);
        check("rst.done", instruction_done, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.alu_go", alu_go, 0);
        check("rst.seq_err", seq_err, 0);

        // Release with ready held high: only the boot kick, no capture.
        k = cyc;
        reset = 1'b0;
        push(EV_DONE, k + 1, 0, 0, 0, "boot");
        retire(4);
        check("boot.seq_err", seq_err, 0);

        // LDA #$42
        issue(8'hA9, 16'h0000, 8'h42, k);
        push(EV_ALU, k + 1, 'h42, 'hA9, 1, "lda_imm");
        push(EV_DONE, k + 2, 0, 0, 0, "lda_imm");
        retire(3);

        // LDY #$05 and INX / DEX implied forms
        issue(8'hA0, 16'h0000, 8'h05, k);
        push(EV_ALU, k + 1, 'h05, 'hA0, 1, "ldy_imm");
        push(EV_DONE, k + 2, 0, 0, 0, "ldy_imm");
        retire(3);
        issue(8'hE8, 16'h0000, 8'h99, k);
        push(EV_ALU, k + 1, 0, 'hE8, 1, "inx");
        push(EV_DONE, k + 2, 0, 0, 0, "inx");
        retire(3);
        issue(8'hCA, 16'h0000, 8'h99, k);
        push(EV_ALU, k + 1, 0, 'hCA, 1, "dex");
        push(EV_DONE, k + 2, 0, 0, 0, "dex");
        retire(3);

        // LDA $0310
        issue(8'hAD, 16'h0310, 8'h00, k);
        push(EV_ALU, k + 2, 'h5A, 'hAD, 1, "lda_abs");
        push(EV_DONE, k + 3, 0, 0, 0, "lda_abs");
        @(negedge phi1);
        check("lda_abs.read_addr", mem_addr, 'h0310);
        check("lda_abs.read_we", mem_we, 0);
        retire(3);

        // STX $20 and STA $1234
        issue(8'h86, 16'h0020, 8'h00, k);
        push(EV_WR, k + 1, 'h0020, 'h77, 0, "stx");
        push(EV_DONE, k + 2, 0, 0, 0, "stx");
        @(negedge phi1);
        check("stx.store_sel", store_sel, 1);
        retire(2);
        issue(8'h8D, 16'h1234, 8'h00, k);
        push(EV_WR, k + 1, 'h1234, 'h11, 0, "sta");
        push(EV_DONE, k + 2, 0, 0, 0, "sta");
        retire(3);

        // INC $40: read FE, ALU gives FF
        issue(8'hE6, 16'h0040, 8'h00, k);
        push(EV_ALU, k + 2, 'hFE, 'hE6, 0, "inc");
`ifdef RMW_DUMMY_WRITE_EN
        push(EV_WR, k + 3, 'h0040, 'hFE, 0, "inc_dummy");
        push(EV_WR, k + 4, 'h0040, 'hFF, 0, "inc");
        push(EV_DONE, k + 5, 0, 0, 0, "inc");
        retire(6);
`else
        push(EV_WR, k + 3, 'h0040, 'hFF, 0, "inc");
        push(EV_DONE, k + 4, 0, 0, 0, "inc");
        retire(5);
`endif

        // STY $55 with a new ready edge landing on DONE: dropped, no error.
        issue(8'h84, 16'h0055, 8'h00, k);
        push(EV_WR, k + 1, 'h0055, 'h33, 0, "sty");
        push(EV_DONE, k + 2, 0, 0, 0, "sty");
        @(negedge phi1);
        check("sty.store_sel", store_sel, 2);
        instruction_ready = 1'b0;
        @(negedge phi1);
        instruction_ready = 1'b1;
        repeat (3) @(negedge phi1);
        check("done_edge.seq_err", seq_err, 0);
        instruction_ready = 1'b0;
        repeat (2) @(negedge phi1);

        // LDA $0310 with a fresh edge while busy: ignored, sticky error.
        issue(8'hAD, 16'h0310, 8'h00, k);
        push(EV_ALU, k + 2, 'h5A, 'hAD, 1, "lda_busy");
        push(EV_DONE, k + 3, 0, 0, 0, "lda_busy");
        @(negedge phi1);
        instruction_ready = 1'b0;
        @(negedge phi1);
        instruction_ready = 1'b1;
        repeat (3) @(negedge phi1);
        check("busy_edge.seq_err", seq_err, 1);
        retire(1);
        check("busy_edge.seq_err_sticky", seq_err, 1);

        // STX with reset landing in WRITE: write dropped, boot kick after release.
        issue(8'h86, 16'h0020, 8'h00, k);
        @(posedge phi1);
        #1 reset = 1'b1;
        @(negedge phi1);
        check("rst_mid.mem_we", mem_we, 0);
        check("rst_mid.done", instruction_done, 0);
        check("rst_mid.alu_op", alu_op, 0);
        check("rst_mid.seq_err", seq_err, 0);
        repeat (2) @(negedge phi1);
        k = cyc;
        reset = 1'b0;
        push(EV_DONE, k + 1, 0, 0, 0, "reboot");
        retire(4);

        repeat (3) @(negedge phi1);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
